// File: rtl/inst_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, fetches over a req/ack handshake,
// gates register-file and data-memory strobes from decoder fields, resolves branches.
module inst_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     inst,
  input  logic [2:0]      bs,
  input  logic [5:0]      off,
  input  logic            halt,
  input  logic            md,
  input  logic            mw,
  input  logic            ld,
  input  logic            zero,
  input  logic            neg,
  output logic            rf_we,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [15:0]     retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_MEM   = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     retire_q, retire_d;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] off_ext_s;
  logic            taken_s;

  function automatic logic branch_taken(input logic [2:0] sel, input logic z, input logic n);
    case (sel)
      3'b000:  return z;
      3'b001:  return ~z;
      3'b010:  return ~n;
      3'b011:  return n;
      default: return 1'b0;
    endcase
  endfunction

  // PC arithmetic wraps silently at PC_W bits
  assign pc_inc_s  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign off_ext_s = PC_W'($signed(off));
  assign taken_s   = branch_taken(bs, zero, neg);

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = ir_q;
  assign retire_cnt = retire_q;
  assign halted     = (state_q == S_IDLE);

  // State, PC, IR and retire counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      retire_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      retire_q <= retire_d;
    end
  end

  // Next-state and strobe decode from the registered state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    retire_d = retire_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (halt) begin
          pc_d    = pc_inc_s;
          state_d = S_IDLE;
        end else if (md) begin
          state_d = S_MEM;
        end else begin
          // branches never write the register file, whatever ld says
          rf_we    = ld & (bs == 3'b100);
          pc_d     = taken_s ? (pc_inc_s + off_ext_s) : pc_inc_s;
          retire_d = retire_q + 16'h0001;
          state_d  = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mw;
        if (dmem_ack) begin
          rf_we    = ld;
          pc_d     = pc_inc_s;
          retire_d = retire_q + 16'h0001;
          state_d  = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed scenarios with literal expectations, then
// randomized programs/handshakes checked every cycle against an instruction-level model.
module tb_inst_sequencer;

  localparam int PC_W = 8;
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_MEM = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic            imem_ack = 1'b0, dmem_ack = 1'b0;
  logic            zero = 1'b0, neg = 1'b0;
  logic [15:0]     imem_data = 16'h0000;
  logic [PC_W-1:0] imem_addr, pc;
  logic            imem_req, rf_we, dmem_req, dmem_we, halted;
  logic [15:0]     inst, retire_cnt;
  logic [2:0]      bs;
  logic [5:0]      off;
  logic            halt, md, mw, ld;

  always #5 clk = ~clk;

  inst_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst(inst), .bs(bs), .off(off), .halt(halt), .md(md), .mw(mw), .ld(ld),
    .zero(zero), .neg(neg), .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .pc(pc), .halted(halted), .retire_cnt(retire_cnt)
  );

  // Bench-side decoder: [15:14]==01 memory op, [13] MW, [11:9]^100 BS, [7] LD, [5:0] OFF
  function automatic logic [2:0] d_bs(input logic [15:0] w); return w[11:9] ^ 3'b100; endfunction
  function automatic logic d_md(input logic [15:0] w); return w[15:14] == 2'b01; endfunction
  function automatic logic d_mw(input logic [15:0] w); return w[13]; endfunction
  function automatic logic d_ld(input logic [15:0] w); return w[7]; endfunction
  function automatic logic d_halt(input logic [15:0] w); return w == 16'h0001; endfunction
  function automatic logic [15:0] mk(input logic m, input logic w, input logic [2:0] b,
                                     input logic l, input logic [5:0] o);
    return {1'b0, m, w, 1'b0, b ^ 3'b100, 1'b0, l, 1'b0, o};
  endfunction

  assign bs   = d_bs(inst);
  assign off  = inst[5:0];
  assign halt = d_halt(inst);
  assign md   = d_md(inst);
  assign mw   = d_mw(inst);
  assign ld   = d_ld(inst);

  logic [15:0] mem [256];
  int checks = 0, errors = 0;
  int n_rf = 0, n_dreq = 0, n_dwe = 0;
  int i_cnt = 0, d_cnt = 0, i_wait = 0, d_wait = 0;
  bit rand_mode = 1'b0, chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  int          m_phase = P_IDLE;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000, m_ret = 16'h0000;

  function automatic logic [7:0] next_pc(input logic [15:0] w, input logic [7:0] p,
                                         input logic z, input logic n);
    int o, t;
    o = int'(w[5:0]);
    if (o >= 32) o = o - 64;
    case (d_bs(w))
      3'd0: t = z ? 1 : 0;
      3'd1: t = z ? 0 : 1;
      3'd2: t = n ? 0 : 1;
      3'd3: t = n ? 1 : 0;
      default: t = 0;
    endcase
    return 8'((int'(p) + 1 + ((t != 0) ? o : 0)) & 255);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE; m_pc <= 8'h00; m_ir <= 16'h0000; m_ret <= 16'h0000;
    end else begin
      case (m_phase)
        P_IDLE:  if (run) m_phase <= P_FETCH;
        P_FETCH: if (imem_ack) begin m_ir <= imem_data; m_phase <= P_EXEC; end
        P_EXEC: begin
          if (d_halt(m_ir)) begin
            m_pc <= m_pc + 8'd1; m_phase <= P_IDLE;
          end else if (d_md(m_ir)) begin
            m_phase <= P_MEM;
          end else begin
            m_pc <= next_pc(m_ir, m_pc, zero, neg); m_ret <= m_ret + 16'd1; m_phase <= P_FETCH;
          end
        end
        P_MEM: if (dmem_ack) begin m_pc <= m_pc + 8'd1; m_ret <= m_ret + 16'd1; m_phase <= P_FETCH; end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("imem_req", imem_req, m_phase == P_FETCH);
      check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("inst", inst, m_ir);
      check("halted", halted, m_phase == P_IDLE);
      check("retire_cnt", retire_cnt, m_ret);
      check("rf_we", rf_we,
            (m_phase == P_EXEC && !d_halt(m_ir) && !d_md(m_ir) && d_ld(m_ir) && d_bs(m_ir) == 3'b100) ||
            (m_phase == P_MEM && dmem_ack && d_ld(m_ir)));
      check("dmem_req", dmem_req, m_phase == P_MEM);
      check("dmem_we", dmem_we, m_phase == P_MEM && d_mw(m_ir));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) n_rf++;
      if (dmem_req) n_dreq++;
      if (dmem_we) n_dwe++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (imem_req) begin imem_ack = (i_cnt >= i_wait); i_cnt++; end
    else begin imem_ack = 1'b0; i_cnt = 0; end
    if (dmem_req) begin dmem_ack = (d_cnt >= d_wait); d_cnt++; end
    else begin dmem_ack = 1'b0; d_cnt = 0; end
    imem_data = mem[imem_addr];
    if (rand_mode) begin
      if (imem_ack) i_wait = $urandom_range(0, 3);
      if (dmem_ack) d_wait = $urandom_range(0, 3);
      zero = 1'($urandom);
      neg  = 1'($urandom);
      run  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    i_cnt = 0; d_cnt = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_pulse();
    run = 1'b1; cyc(); run = 1'b0;
  endtask

  task automatic until_halt(input string name);
    for (int k = 0; k < 200 && !halted; k++) cyc();
    check(name, halted, 1'b1);
  endtask

  task automatic until_retire(input string name, input logic [15:0] tgt);
    for (int k = 0; k < 200 && retire_cnt != tgt; k++) cyc();
    check(name, retire_cnt, tgt);
  endtask

  task automatic fill_nop();
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
  endtask

  initial begin
    // A: reset state, then a single ALU write and a HALT
    fill_nop(); mem[0] = 16'hF0C8; mem[1] = 16'h0001;
    i_wait = 0; d_wait = 0;
    do_reset();
    chk_en = 1'b1;
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 1'b1);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_retire", retire_cnt, 16'h0000);
    check("rst_inst", inst, 16'h0000);
    check("rst_strobes", {rf_we, dmem_req, dmem_we}, 3'b000);
    run_pulse();
    check("a_fetch_req", imem_req, 1'b1);
    check("a_fetch_addr", imem_addr, 8'h00);
    cyc();
    check("a_exec_rf_we", rf_we, 1'b1);
    cyc();
    check("a_pc", pc, 8'h01);
    check("a_retire", retire_cnt, 16'h0001);
    check("a_model_pc", m_pc, 8'h01);
    until_halt("a_halt");
    check("a_halt_pc", pc, 8'h02);
    check("a_rf_pulses", n_rf, 1);

    // B: BEQ -2 at pc 5, taken then not taken
    fill_nop(); mem[5] = mk(1'b0, 1'b0, 3'b000, 1'b0, 6'h3E); mem[6] = 16'h0001;
    zero = 1'b1; neg = 1'b0;
    do_reset(); run_pulse();
    until_retire("b_ret6", 16'd6);
    check("b_beq_taken_pc", pc, 8'h04);
    check("b_model_pc", m_pc, 8'h04);
    zero = 1'b0;
    until_retire("b_ret8", 16'd8);
    check("b_beq_not_taken_pc", pc, 8'h06);
    until_halt("b_halt");
    check("b_rf_pulses", n_rf, 0);

    // C: BNE +3 with ld=1 and zero=1 -> not taken, no write
    fill_nop(); mem[5] = mk(1'b0, 1'b0, 3'b001, 1'b1, 6'd3); mem[6] = 16'h0001;
    zero = 1'b1;
    do_reset(); run_pulse();
    until_retire("c_ret6", 16'd6);
    check("c_bne_pc", pc, 8'h06);
    until_halt("c_halt");
    check("c_rf_pulses", n_rf, 0);

    // D: jump back to 0xFF, then BLTZ +1 wraps to 0x01
    fill_nop(); mem[0] = mk(1'b0, 1'b0, 3'b000, 1'b0, 6'h3E);
    mem[255] = mk(1'b0, 1'b0, 3'b011, 1'b0, 6'd1); mem[1] = 16'h0001;
    zero = 1'b1; neg = 1'b1;
    do_reset(); run_pulse();
    until_retire("d_ret1", 16'd1);
    check("d_pc_ff", pc, 8'hFF);
    until_retire("d_ret2", 16'd2);
    check("d_bltz_wrap_pc", pc, 8'h01);
    until_halt("d_halt");
    check("d_halt_pc", pc, 8'h02);

    // E: LB then SB, each with dmem_ack three cycles late
    fill_nop(); mem[0] = mk(1'b1, 1'b0, 3'b100, 1'b1, 6'd0);
    mem[1] = mk(1'b1, 1'b1, 3'b100, 1'b0, 6'd0); mem[2] = 16'h0001;
    d_wait = 3;
    do_reset(); run_pulse();
    until_halt("e_halt");
    check("e_dreq_cycles", n_dreq, 8);
    check("e_dwe_cycles", n_dwe, 4);
    check("e_rf_pulses", n_rf, 1);
    check("e_pc", pc, 8'h03);
    check("e_retire", retire_cnt, 16'd2);
    d_wait = 0;

    // F: HALT at pc 3, then resume at 4
    fill_nop(); mem[3] = 16'h0001; mem[4] = 16'hF0C8; mem[5] = 16'h0001;
    do_reset(); run_pulse();
    until_halt("f_halt1");
    check("f_halt_pc", pc, 8'h04);
    check("f_halt_retire", retire_cnt, 16'd3);
    run_pulse();
    check("f_resume_addr", imem_addr, 8'h04);
    until_halt("f_halt2");
    check("f_final_pc", pc, 8'h06);
    check("f_final_retire", retire_cnt, 16'd4);

    // G: asynchronous reset while a fetch is waiting for ack
    fill_nop();
    do_reset(); run_pulse(); cyc();
    i_wait = 20;
    cyc(); cyc();
    check("g_pending_req", imem_req, 1'b1);
    check("g_pending_pc", pc, 8'h01);
    rst = 1'b1;
    #1;
    check("g_rst_req", imem_req, 1'b0);
    check("g_rst_pc", pc, 8'h00);
    check("g_rst_halted", halted, 1'b1);
    i_wait = 0;

    // Random programs, handshakes, flags, run and occasional resets
    for (int k = 0; k < 256; k++) mem[k] = ($urandom_range(0, 19) == 0) ? 16'h0001 : 16'($urandom);
    rand_mode = 1'b1;
    i_wait = $urandom_range(0, 3); d_wait = $urandom_range(0, 3);
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      cyc();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
    end
    rand_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
